// File: rtl/l1d_axi_master_if.sv
// l1d_axi_master_if: AXI4 read/write channels between the L1D bridge and the system bus.
interface l1d_axi_master_if #(parameter int ID_W = 4);
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  modport master(
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID, AWREADY, WREADY, BID, BRESP, BVALID
  );
  modport slave(
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/l1d_axi_master.sv
// l1d_axi_master: L1 data cache memory port to AXI4 master (4-beat fills, single-beat uncached reads and writes).
module l1d_axi_master #(
  parameter int              ID_W       = 4,
  parameter logic [ID_W-1:0] MST_ID     = 4'd1,
  parameter logic [15:0]     UNCACHE_HI = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait,
  output logic        bus_err,
  l1d_axi_master_if.master axi
);
  localparam logic [2:0] T_BYTE  = 3'd0;
  localparam logic [2:0] T_HWORD = 3'd1;
  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, DONE} state_t;
  state_t      r_state;
  logic [31:0] r_araddr, r_awaddr, r_wdata, r_rdata_q;
  logic [3:0]  r_arlen, r_wstrb;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_bus_err;
  logic        w_cacheable, w_rhs, w_bhs, w_unused;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  assign w_cacheable = D_addr[31:16] != UNCACHE_HI;
  assign w_wstrb = D_type == T_BYTE  ? 4'b0001 << D_addr[1:0] :
                   D_type == T_HWORD ? 4'b0011 << {D_addr[1], 1'b0} : 4'b1111;
  assign w_wdata = D_in << {D_addr[1:0], 3'b000};
  assign w_rhs = r_state == R && axi.RVALID && r_rready;
  assign w_bhs = r_state == B && axi.BVALID && r_bready;
  assign w_unused = ^{axi.RID, axi.BID};
  // Beat data bypasses the register so the cache sees it in the D_wait-low cycle itself.
  assign D_out   = w_rhs ? axi.RDATA : r_rdata_q;
  assign D_wait  = !(w_rhs || w_bhs);
  assign bus_err = r_bus_err;
  assign axi.ARID    = MST_ID;
  assign axi.ARADDR  = r_araddr;
  assign axi.ARLEN   = r_arlen;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = r_arvalid;
  assign axi.RREADY  = r_rready;
  assign axi.AWID    = MST_ID;
  assign axi.AWADDR  = r_awaddr;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = r_awvalid;
  assign axi.WDATA   = r_wdata;
  assign axi.WSTRB   = r_wstrb;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = r_wvalid;
  assign axi.BREADY  = r_bready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_rdata_q <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: if (D_req) begin
          if (D_write) begin
            r_awaddr  <= D_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= AWW;
          end else begin
            r_araddr  <= w_cacheable ? {D_addr[31:4], 4'b0000} : D_addr;
            r_arlen   <= w_cacheable ? 4'd3 : 4'd0;
            r_arvalid <= 1'b1;
            r_state   <= AR;
          end
        end
        AR: if (axi.ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= R;
        end
        R: if (w_rhs) begin
          r_rdata_q <= axi.RDATA;
          r_bus_err <= axi.RRESP != 2'b00;
          if (axi.RLAST) begin
            r_rready <= 1'b0;
            r_state  <= DONE;
          end
        end
        AWW: begin
          if (axi.AWREADY) r_awvalid <= 1'b0;
          if (axi.WREADY) r_wvalid <= 1'b0;
          if ((!r_awvalid || axi.AWREADY) && (!r_wvalid || axi.WREADY)) begin
            r_bready <= 1'b1;
            r_state  <= B;
          end
        end
        B: if (w_bhs) begin
          r_bready  <= 1'b0;
          r_bus_err <= axi.BRESP != 2'b00;
          r_state   <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_l1d_axi_master.sv
// tb_l1d_axi_master: directed scenarios against a hand-driven AXI slave, checked cycle by cycle.
module tb_l1d_axi_master;
  localparam logic [2:0] T_BYTE = 3'd0, T_HWORD = 3'd1, T_WORD = 3'd2;
  logic        clk = 1'b0, rst = 1'b1;
  logic        D_req = 1'b0, D_write = 1'b0;
  logic [31:0] D_addr = '0, D_in = '0;
  logic [2:0]  D_type = T_WORD;
  logic [31:0] D_out;
  logic        D_wait, bus_err;
  int          checks = 0, errors = 0;
  l1d_axi_master_if #(.ID_W(4)) axi();
  l1d_axi_master #(.ID_W(4), .MST_ID(4'd1), .UNCACHE_HI(16'h1000)) dut (
    .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
    .D_type(D_type), .D_out(D_out), .D_wait(D_wait), .bus_err(bus_err), .axi(axi)
  );
  always #5 clk = ~clk;
  task automatic test_reset();
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = '0; axi.RLAST = 0; axi.RID = 4'd1;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = '0; axi.BID = 4'd1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait, bus_err, D_out} !== {5'b0, 1'b1, 1'b0, 32'h0})
      begin errors++; $display("FAIL reset_state: got %b/%h exp 0000010/00000000", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait, bus_err}, D_out); end
    checks++;
    if ({axi.ARADDR, axi.ARLEN, axi.AWADDR, axi.WSTRB} !== 72'h0)
      begin errors++; $display("FAIL reset_regs: got %h exp 0", {axi.ARADDR, axi.ARLEN, axi.AWADDR, axi.WSTRB}); end
    rst = 0;
  endtask
  task automatic test_fill();
    logic [31:0] beat [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    bit vld [7] = '{0, 1, 1, 0, 1, 0, 1};
    int k = 0, lows = 0;
    @(negedge clk); D_req = 1; D_write = 0; D_addr = 32'h0000_1234;
    @(negedge clk); #1;
    checks++;
    if ({axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARID} !== {1'b1, 32'h0000_1230, 4'd3, 3'd2, 2'b01, 4'd1})
      begin errors++; $display("FAIL fill_ar: got %h exp %h", {axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARID}, {1'b1, 32'h0000_1230, 4'd3, 3'd2, 2'b01, 4'd1}); end
    axi.ARREADY = 1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      axi.ARREADY = 0; axi.RVALID = vld[c]; axi.RDATA = vld[c] ? beat[k] : 32'h5555_5555; axi.RLAST = vld[c] && k == 3;
      #1;
      lows += !D_wait;
      checks++;
      if (vld[c] && {axi.RREADY, D_wait, D_out} !== {2'b10, beat[k]})
        begin errors++; $display("FAIL fill_beat%0d: got rready/wait %b%b data %h exp 10 %h", k, axi.RREADY, D_wait, D_out, beat[k]); end
      else if (!vld[c] && {axi.RREADY, D_wait} !== 2'b11)
        begin errors++; $display("FAIL fill_gap%0d: got rready/wait %b%b exp 11", c, axi.RREADY, D_wait); end
      if (vld[c]) k++;
    end
    @(negedge clk); axi.RVALID = 0; axi.RLAST = 0; #1;
    checks++;
    if ({axi.RREADY, D_wait, D_out} !== {2'b01, beat[3]})
      begin errors++; $display("FAIL fill_done: got %b%b %h exp 01 %h", axi.RREADY, D_wait, D_out, beat[3]); end
    checks++;
    if (lows !== 4) begin errors++; $display("FAIL fill_lows: got %0d exp 4", lows); end
    D_req = 0;
    @(negedge clk); #1;
    checks++;
    if ({axi.ARVALID, axi.RREADY, D_wait} !== 3'b001)
      begin errors++; $display("FAIL fill_idle: got %b exp 001", {axi.ARVALID, axi.RREADY, D_wait}); end
  endtask
  task automatic test_sensor_read();
    @(negedge clk); D_req = 1; D_write = 0; D_addr = 32'h1000_0008;
    @(negedge clk); #1;
    checks++;
    if ({axi.ARVALID, axi.ARADDR, axi.ARLEN} !== {1'b1, 32'h1000_0008, 4'd0})
      begin errors++; $display("FAIL sensor_ar: got %h exp 11000000080", {axi.ARVALID, axi.ARADDR, axi.ARLEN}); end
    @(negedge clk); #1;
    checks++;
    if ({axi.ARVALID, axi.ARADDR, D_wait} !== {1'b1, 32'h1000_0008, 1'b1})
      begin errors++; $display("FAIL sensor_ar_hold: got %b %h %b exp 1 10000008 1", axi.ARVALID, axi.ARADDR, D_wait); end
    axi.ARREADY = 1;
    @(negedge clk); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = 32'hDEAD_BEEF; axi.RLAST = 1; #1;
    checks++;
    if ({D_wait, D_out} !== {1'b0, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL sensor_beat: got %b %h exp 0 deadbeef", D_wait, D_out); end
    @(negedge clk); axi.RVALID = 0; axi.RLAST = 0; axi.RDATA = 32'h0; D_req = 0; #1;
    checks++;
    if ({D_wait, D_out} !== {1'b1, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL sensor_hold: got %b %h exp 1 deadbeef", D_wait, D_out); end
    @(negedge clk);
  endtask
  task automatic test_byte_store();
    @(negedge clk); D_req = 1; D_write = 1; D_type = T_BYTE; D_addr = 32'h0000_2003; D_in = 32'h0000_00AB;
    @(negedge clk); #1;
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.WSTRB, axi.WDATA, axi.WLAST, D_wait} !==
        {2'b11, 32'h0000_2003, 4'd0, 3'd2, 4'b1000, 32'hAB00_0000, 1'b1, 1'b1})
      begin errors++; $display("FAIL byte_aw_w: got addr %h strb %b data %h v %b%b wait %b", axi.AWADDR, axi.WSTRB, axi.WDATA, axi.AWVALID, axi.WVALID, D_wait); end
    axi.AWREADY = 1; axi.WREADY = 1;
    @(negedge clk); axi.AWREADY = 0; axi.WREADY = 0; #1;
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== 4'b0011)
      begin errors++; $display("FAIL byte_b_wait: got %b exp 0011", {axi.AWVALID, axi.WVALID, axi.BREADY, D_wait}); end
    @(negedge clk); axi.BVALID = 1; axi.BRESP = 2'b00; #1;
    checks++;
    if ({D_wait, bus_err} !== 2'b00) begin errors++; $display("FAIL byte_bresp: got %b exp 00", {D_wait, bus_err}); end
    @(negedge clk); axi.BVALID = 0; D_req = 0; #1;
    checks++;
    if ({D_wait, bus_err, axi.BREADY} !== 3'b100) begin errors++; $display("FAIL byte_done: got %b exp 100", {D_wait, bus_err, axi.BREADY}); end
    @(negedge clk);
  endtask
  task automatic test_hword_store();
    int lows = 0;
    @(negedge clk); D_req = 1; D_write = 1; D_type = T_HWORD; D_addr = 32'h0000_3002; D_in = 32'h0000_1234;
    @(negedge clk); #1;
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.WSTRB, axi.WDATA} !== {2'b11, 4'b1100, 32'h1234_0000})
      begin errors++; $display("FAIL hword_w: got v %b%b strb %b data %h exp 11 1100 12340000", axi.AWVALID, axi.WVALID, axi.WSTRB, axi.WDATA); end
    axi.WREADY = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); axi.WREADY = 0; #1;
      lows += !D_wait;
      checks++;
      if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b100)
        begin errors++; $display("FAIL hword_aw_wait%0d: got %b exp 100", c, {axi.AWVALID, axi.WVALID, axi.BREADY}); end
    end
    axi.AWREADY = 1;
    @(negedge clk); axi.AWREADY = 0; axi.BVALID = 1; #1;
    lows += !D_wait;
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== 4'b0010)
      begin errors++; $display("FAIL hword_b: got %b exp 0010", {axi.AWVALID, axi.WVALID, axi.BREADY, D_wait}); end
    @(negedge clk); axi.BVALID = 0; D_req = 0; #1;
    lows += !D_wait;
    checks++;
    if (lows !== 1) begin errors++; $display("FAIL hword_lows: got %0d exp 1", lows); end
    @(negedge clk);
  endtask
  task automatic test_bus_error();
    @(negedge clk); D_req = 1; D_write = 1; D_type = T_WORD; D_addr = 32'h0000_4000; D_in = 32'hCAFE_F00D;
    @(negedge clk); #1;
    checks++;
    if ({axi.WSTRB, axi.WDATA} !== {4'b1111, 32'hCAFE_F00D})
      begin errors++; $display("FAIL err_w: got %b %h exp 1111 cafef00d", axi.WSTRB, axi.WDATA); end
    axi.AWREADY = 1; axi.WREADY = 1;
    @(negedge clk); axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 1; axi.BRESP = 2'b10; #1;
    checks++;
    if ({D_wait, bus_err} !== 2'b00) begin errors++; $display("FAIL err_bcycle: got %b exp 00", {D_wait, bus_err}); end
    @(negedge clk); axi.BVALID = 0; axi.BRESP = 2'b00; D_req = 0; #1;
    checks++;
    if ({D_wait, bus_err} !== 2'b11) begin errors++; $display("FAIL err_pulse: got %b exp 11", {D_wait, bus_err}); end
    @(negedge clk); #1;
    checks++;
    if ({D_wait, bus_err, axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID} !== 6'b100000)
      begin errors++; $display("FAIL err_idle: got %b exp 100000", {D_wait, bus_err, axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID}); end
  endtask
  task automatic test_reset_mid_fill();
    logic [31:0] beat [4] = '{32'hC0C0_0001, 32'hC1C1_0002, 32'hC2C2_0003, 32'hC3C3_0004};
    int lows = 0;
    @(negedge clk); D_req = 1; D_write = 0; D_addr = 32'h0000_5678;
    @(negedge clk); axi.ARREADY = 1;
    @(negedge clk); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = 32'hB0B0_B0B0;
    @(negedge clk); axi.RDATA = 32'hB1B1_B1B1;
    @(negedge clk); axi.RVALID = 0; rst = 1; #1;
    checks++;
    if ({axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait, D_out} !== {5'b0, 1'b1, 32'h0})
      begin errors++; $display("FAIL async_rst: got %b %h exp 000001 00000000", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait}, D_out); end
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    checks++;
    if ({axi.ARVALID, axi.ARADDR, axi.ARLEN} !== {1'b1, 32'h0000_5670, 4'd3})
      begin errors++; $display("FAIL refill_ar: got %h exp 10000056703", {axi.ARVALID, axi.ARADDR, axi.ARLEN}); end
    axi.ARREADY = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = beat[k]; axi.RLAST = k == 3; #1;
      lows += !D_wait;
      checks++;
      if ({D_wait, D_out} !== {1'b0, beat[k]})
        begin errors++; $display("FAIL refill_beat%0d: got %b %h exp 0 %h", k, D_wait, D_out, beat[k]); end
    end
    @(negedge clk); axi.RVALID = 0; axi.RLAST = 0; D_req = 0; #1;
    lows += !D_wait;
    checks++;
    if (lows !== 4) begin errors++; $display("FAIL refill_lows: got %0d exp 4", lows); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_fill();
    test_sensor_read();
    test_byte_store();
    test_hword_store();
    test_bus_error();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1d_axi_master.md
Name: l1d_axi_master

Overview:
- Bridges the L1 data cache memory-side port (D_req/D_addr/D_write/D_in/D_type → D_out/D_wait) onto an AXI4 master interface toward the system bus.
- Cacheable reads become 4-beat INCR line-fill bursts. Uncacheable (sensor region) reads become single-beat reads. All writes are single-beat write-through with byte strobes.
- Sits directly downstream of the data cache, inside the CPU wrapper.

Parameters:
- ID_W, 4, AXI ID width.
- MST_ID, 4'd1, constant ID driven on ARID/AWID.
- UNCACHE_HI, 16'h1000, address bits [31:16] of the uncacheable sensor region.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- D_req  in  1  cache request, held until completion
- D_addr  in  32  request address (line-aligned for fills)
- D_write  in  1  1 = write, 0 = read
- D_in  in  32  store data, unshifted (LSB-aligned)
- D_type  in  3  `CACHE_BYTE/HWORD/WORD/BYTE_U/HWORD_U
- D_out  out  32  read data beat
- D_wait  out  1  0 = beat delivered / write done this cycle
- bus_err  out  1  one-cycle pulse on non-OKAY RRESP/BRESP
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID_W/32/4/3/2/1  read address channel
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RVALID  in  ID_W/32/2/1/1  read data channel
- RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_W/32/4/3/2/1  write address channel
- AWREADY  in  1
- WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data channel
- WREADY  in  1
- BID/BRESP/BVALID  in  ID_W/2/1  write response channel
- BREADY  out  1

Behaviour:
- States: IDLE, AR, R, AWW, B, DONE. Async reset → IDLE.
- Reset values: all VALID/READY outputs 0, D_wait=1, D_out=0 (rdata_q=0), bus_err=0, address/len/strb registers 0.
- Reset mid-transaction aborts immediately to IDLE. No outstanding-transaction tracking.
- IDLE, D_req=1 & D_write=0:
  - Latch addr.
  - cacheable = (D_addr[31:16] != UNCACHE_HI).
  - ARLEN = cacheable ? 3 : 0; ARADDR = cacheable ? {D_addr[31:4],4'b0} : D_addr.
  - ARSIZE=3'b010, ARBURST=INCR. Go to AR.
- IDLE, D_req=1 & D_write=1:
  - AWADDR = D_addr, AWLEN=0, AWSIZE=2, AWBURST=INCR.
  - WSTRB by D_type: BYTE → 4'b0001<<addr[1:0]; HWORD → 4'b0011<<{addr[1],1'b0}; WORD/other → 4'b1111.
  - WDATA = D_in << (8*addr[1:0]); WLAST=1. Go to AWW.
- AR: ARVALID=1 until ARREADY, then go to R.
- R:
  - RREADY=1.
  - On each RVALID&RREADY: D_wait=0 combinationally that same cycle; D_out=RDATA combinationally; rdata_q<=RDATA.
  - RLAST handshake → DONE.
- D_out outside a handshake cycle = rdata_q. This lets the uncacheable path sample read data one cycle after D_wait falls.
- Fill beats are delivered in address order. The cache counts one beat per D_wait-low cycle, so exactly ARLEN+1 low cycles per read.
- AWW:
  - AWVALID and WVALID both asserted from entry. Each deasserts individually on its handshake (either order, or same cycle).
  - When both are done, go to B.
- B: BREADY=1. On BVALID: D_wait=0 for that one cycle, then DONE.
- DONE: D_wait=1 and D_req ignored for one cycle (the cache drops D_req there), then IDLE.
- bus_err pulses (registered, one cycle) if RRESP≠OKAY on any beat or BRESP≠OKAY. The transfer still completes normally.
- D_wait=1 in all cycles other than the handshake cycles listed above. Consecutive R beats produce consecutive D_wait-low cycles.
- RID/BID are not checked (single master ID, one outstanding transaction).
- ARVALID/AWVALID/WVALID are never withdrawn before their handshake completes; their payloads are stable while VALID.

Test Plan:
- Cacheable fill: D_req read D_addr=0x0000_1234 → ARADDR=0x0000_1230, ARLEN=3. RDATA beats A0..A3 with RVALID gaps → D_wait low exactly 4 cycles, D_out=A0..A3 in those cycles. Return to IDLE after DONE.
- Sensor read: D_addr=0x1000_0008 → ARADDR=0x1000_0008, ARLEN=0. RDATA=0xDEAD_BEEF → one D_wait-low cycle; D_out holds 0xDEAD_BEEF the next cycle.
- Byte store: D_type=BYTE, D_addr=0x0000_2003, D_in=0x0000_00AB → WSTRB=4'b1000, WDATA=0xAB00_0000. D_wait low only in the BVALID cycle.
- Halfword store at addr[1]=1 with AWREADY delayed 3 cycles after WREADY → WSTRB=4'b1100. AWVALID/WVALID each drop only after their own handshake. Single completion pulse.
- Error response: BRESP=2'b10 on a word write → bus_err one-cycle pulse; D_wait low once; FSM returns to IDLE.
- Async rst asserted during R after beat 2 → all VALID/READY=0 and D_wait=1 immediately. A new fill after reset completes with 4 beats.
